decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the lab CPU, sitting between fetch and execute.
- Decodes the 12-op ISA (br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause) into a one-hot vector with operand fields and an illegal flag.
- Holds the result in a one-entry pipeline register with valid/ready handshakes on both sides.
- Adds three behaviours: a flush for taken branches, a stall of PAUSE_CYCLES after each pause, and illegal-encoding detection.

Parameters:
- IW, 8: instruction width. Opcode is always the top 6 bits, instr[IW-1:IW-6]. Legal range: IW >= max(6+REG_W, 4+2*REG_W).
- REG_W, 2: register-select width.
- PAUSE_CYCLES, 16: in_ready low-cycles after a pause is handed off. 0 means no stall.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  kill the held instruction and any pending pause stall.
- in_valid  in  1  fetch offers instr.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  IW  instruction word.
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  execute consumes this cycle.
- op  out  12  one-hot, bit order br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause (bit 0 = br).
- illegal  out  1  held word matches no opcode.
- rd  out  REG_W  destination register.
- rs  out  REG_W  source register (mov only, else 0).
- imm  out  IW-3  immediate or branch offset.
- pausing  out  1  pause counter nonzero.

Behaviour:
- **Reset** (sync, wins over everything): out_valid=0, op=0, illegal=0, rd=0, rs=0, imm=0, pause_cnt=0, pausing=0.
- **Decode patterns** on opcode o = instr[IW-1:IW-6]:
  - br: o[5:3]=100. brz: 101. addi: 000. subi: 001.
  - sr0: o[5:2]=0100. srh0: 0101. mov: 0111.
  - clr: 011000. mova: 110000. movr: 110001. movrhs: 110010. pause: 111111.
  - Any other pattern (0110_01, 0110_1x, 110011..111110): op=0, illegal=1, rd=rs=imm=0.
- **Field extraction**:
  - br/brz: imm = instr[IW-4:0], a raw two's-complement offset; rd=0.
  - addi/subi: rd = instr[IW-4 -: REG_W]; imm = zero-extended instr[IW-4-REG_W:0].
  - sr0/srh0: imm = zero-extended instr[IW-5:0].
  - mov: rd = instr[IW-5 -: REG_W]; rs = instr[REG_W-1:0].
  - clr/mova/movr/movrhs: rd = instr[REG_W-1:0]. Bits above REG_W in the operand field are ignored.
  - Unused fields are driven to 0.
- **Handshake**:
  - in_ready = !flush && pause_cnt==0 && !(out_valid && op[pause]) && (!out_valid || out_ready). This is combinational.
  - Accept (in_valid && in_ready): decoded fields register on that edge; out_valid=1 next cycle. Latency is 1 cycle.
  - Consume (out_valid && out_ready) with no accept in the same cycle: out_valid falls to 0 next cycle.
  - Consume and accept in the same cycle: the register is replaced, out_valid stays 1. This gives full throughput.
  - The output register is stable while out_valid && !out_ready.
- **Pause**:
  - A held pause blocks new input until it is consumed.
  - On consume of a pause at edge T: pause_cnt = PAUSE_CYCLES at T+1. The counter decrements each cycle to 0.
  - in_ready=0 during cycles T+1..T+PAUSE_CYCLES; in_ready can rise at T+PAUSE_CYCLES+1.
  - pausing = (pause_cnt != 0).
  - Counter width is max(1, $clog2(PAUSE_CYCLES+1)). With PAUSE_CYCLES=0 there is no stall cycle.
- **Flush**:
  - Next cycle: out_valid=0, pause_cnt=0.
  - in_ready=0 in the flush cycle, so no instruction is taken. Flush beats a simultaneous accept or consume-reload.
  - An out_ready handshake in the flush cycle still counts as consumed by execute.
- Illegal words flow through the handshake like any other word. No sticky state.

Decomposition:
- Package decode_pkg:
  - op-index localparams OP_BR..OP_PAUSE and NUM_OPS=12.
  - 6-bit opcode pattern constants.
  - a function returning the one-hot op from a 6-bit opcode.
- Sub-module decode_fields: purely combinational (instr → op, illegal, rd, rs, imm), parametrised by IW and REG_W.
- decode_stage adds the pipeline register, handshake, pause counter and flush logic.

Test Plan (IW=8, REG_W=2, PAUSE_CYCLES=4):
- instr 0x15 accepted with out_ready=1 → next cycle out_valid=1, op=addi, rd=2, imm=5, illegal=0. Back-to-back 0x9D → op=br, imm=0x1D; no bubbles.
- 0x7D with out_ready=0 for 3 cycles → op=mov, rd=3, rs=1 held stable; in_ready=0 throughout; consumed on the 4th cycle.
- 0xFC (pause) consumed at T → pausing=1 and in_ready=0 for T+1..T+4; in_ready=1 at T+5. The next instruction presented at T+1 is accepted at T+5.
- 0x64 and 0xF8 → illegal=1, op=0. Then 0x61 → op=clr, rd=1.
- Held 0x15 (out_ready=0) plus flush with in_valid=1 (0x9D) in the same cycle → out_valid=0 next cycle and 0x9D is not accepted. Flush at T+2 of a pause stall → in_ready=1 at T+3.
- reset asserted mid-stall with out_valid=1 → next cycle all outputs 0 and in_ready=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: op indices, opcode patterns and
// the opcode-to-one-hot mapping.
package decode_pkg;

  localparam int NUM_OPS   = 12;
  localparam int OP_BR     = 0;
  localparam int OP_BRZ    = 1;
  localparam int OP_ADDI   = 2;
  localparam int OP_SUBI   = 3;
  localparam int OP_SR0    = 4;
  localparam int OP_SRH0   = 5;
  localparam int OP_CLR    = 6;
  localparam int OP_MOV    = 7;
  localparam int OP_MOVA   = 8;
  localparam int OP_MOVR   = 9;
  localparam int OP_MOVRHS = 10;
  localparam int OP_PAUSE  = 11;

  // 3-bit prefixes (opcode bits [5:3])
  localparam logic [2:0] OPC3_BR     = 3'b100;
  localparam logic [2:0] OPC3_BRZ    = 3'b101;
  localparam logic [2:0] OPC3_ADDI   = 3'b000;
  localparam logic [2:0] OPC3_SUBI   = 3'b001;
  // 4-bit prefixes (opcode bits [5:2])
  localparam logic [3:0] OPC4_SR0    = 4'b0100;
  localparam logic [3:0] OPC4_SRH0   = 4'b0101;
  localparam logic [3:0] OPC4_MOV    = 4'b0111;
  // full 6-bit opcodes
  localparam logic [5:0] OPC6_CLR    = 6'b011000;
  localparam logic [5:0] OPC6_MOVA   = 6'b110000;
  localparam logic [5:0] OPC6_MOVR   = 6'b110001;
  localparam logic [5:0] OPC6_MOVRHS = 6'b110010;
  localparam logic [5:0] OPC6_PAUSE  = 6'b111111;

  // One-hot op for a 6-bit opcode; all-zero means the encoding is illegal.
  // The prefix groups are disjoint, so chain order does not matter.
  function automatic logic [NUM_OPS-1:0] decode_op(input logic [5:0] opc);
    logic [NUM_OPS-1:0] op;
    op = {NUM_OPS{1'b0}};
    if (opc[5:3] == OPC3_BR)          op[OP_BR]     = 1'b1;
    else if (opc[5:3] == OPC3_BRZ)    op[OP_BRZ]    = 1'b1;
    else if (opc[5:3] == OPC3_ADDI)   op[OP_ADDI]   = 1'b1;
    else if (opc[5:3] == OPC3_SUBI)   op[OP_SUBI]   = 1'b1;
    else if (opc[5:2] == OPC4_SR0)    op[OP_SR0]    = 1'b1;
    else if (opc[5:2] == OPC4_SRH0)   op[OP_SRH0]   = 1'b1;
    else if (opc[5:2] == OPC4_MOV)    op[OP_MOV]    = 1'b1;
    else if (opc == OPC6_CLR)         op[OP_CLR]    = 1'b1;
    else if (opc == OPC6_MOVA)        op[OP_MOVA]   = 1'b1;
    else if (opc == OPC6_MOVR)        op[OP_MOVR]   = 1'b1;
    else if (opc == OPC6_MOVRHS)      op[OP_MOVRHS] = 1'b1;
    else if (opc == OPC6_PAUSE)       op[OP_PAUSE]  = 1'b1;
    else                              op = {NUM_OPS{1'b0}};
    return op;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational decoder: instruction word to one-hot op, illegal flag and
// operand fields. Fields not used by the decoded op are zero.
module decode_fields
  import decode_pkg::*;
#(
  parameter int IW    = 8,
  parameter int REG_W = 2
) (
  input  logic [IW-1:0]      instr,
  output logic [NUM_OPS-1:0] op,
  output logic               illegal,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [IW-4:0]      imm
);

  logic [5:0] opc_s;
  assign opc_s = instr[IW-1 -: 6];

  // Decode op and extract the operand fields that belong to it.
  always_comb begin
    op      = decode_op(opc_s);
    illegal = (op == {NUM_OPS{1'b0}});
    rd      = {REG_W{1'b0}};
    rs      = {REG_W{1'b0}};
    imm     = {(IW-3){1'b0}};
    if (op[OP_BR] || op[OP_BRZ]) begin
      imm = instr[IW-4:0];
    end else if (op[OP_ADDI] || op[OP_SUBI]) begin
      rd  = instr[IW-4 -: REG_W];
      imm = {{REG_W{1'b0}}, instr[IW-4-REG_W:0]};
    end else if (op[OP_SR0] || op[OP_SRH0]) begin
      imm = {1'b0, instr[IW-5:0]};
    end else if (op[OP_MOV]) begin
      rd = instr[IW-5 -: REG_W];
      rs = instr[REG_W-1:0];
    end else if (op[OP_CLR] || op[OP_MOVA] || op[OP_MOVR] || op[OP_MOVRHS]) begin
      rd = instr[REG_W-1:0];
    end else begin
      rd  = {REG_W{1'b0}};
      rs  = {REG_W{1'b0}};
      imm = {(IW-3){1'b0}};
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: one-entry output
// register with valid/ready on both sides, post-pause stall and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int IW           = 8,
  parameter int REG_W        = 2,
  parameter int PAUSE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IW-1:0]      instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OPS-1:0] op,
  output logic               illegal,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [IW-4:0]      imm,
  output logic               pausing
);

  localparam int CW = (PAUSE_CYCLES < 1) ? 1 : $clog2(PAUSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PAUSE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [NUM_OPS-1:0] dec_op_s;
  logic               dec_illegal_s;
  logic [REG_W-1:0]   dec_rd_s;
  logic [REG_W-1:0]   dec_rs_s;
  logic [IW-4:0]      dec_imm_s;

  logic               out_valid_r;
  logic [NUM_OPS-1:0] op_r;
  logic               illegal_r;
  logic [REG_W-1:0]   rd_r;
  logic [REG_W-1:0]   rs_r;
  logic [IW-4:0]      imm_r;
  logic [CW-1:0]      pause_cnt_r;
  logic [CW-1:0]      pause_cnt_next_s;
  logic               pausing_r;

  logic               in_ready_s;
  logic               accept_s;
  logic               consume_s;

  decode_fields #(.IW(IW), .REG_W(REG_W)) u_fields (
    .instr   (instr),
    .op      (dec_op_s),
    .illegal (dec_illegal_s),
    .rd      (dec_rd_s),
    .rs      (dec_rs_s),
    .imm     (dec_imm_s)
  );

  // A held pause and a running stall both keep fetch out; flush blocks the take.
  assign in_ready_s = !flush && (pause_cnt_r == CNT_ZERO)
                    && !(out_valid_r && op_r[OP_PAUSE])
                    && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign consume_s  = out_valid_r && out_ready;

  // Next stall count: flush clears it, consuming a pause loads it, else count down.
  always_comb begin
    pause_cnt_next_s = pause_cnt_r;
    if (flush) begin
      pause_cnt_next_s = CNT_ZERO;
    end else if (consume_s && op_r[OP_PAUSE]) begin
      pause_cnt_next_s = CNT_LOAD;
    end else if (pause_cnt_r != CNT_ZERO) begin
      pause_cnt_next_s = pause_cnt_r - CNT_ONE;
    end else begin
      pause_cnt_next_s = CNT_ZERO;
    end
  end

  // Stall counter and its registered nonzero flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_cnt_r <= CNT_ZERO;
      pausing_r   <= 1'b0;
    end else begin
      pause_cnt_r <= pause_cnt_next_s;
      pausing_r   <= (pause_cnt_next_s != CNT_ZERO);
    end
  end

  // Output register: load on accept, drop on consume, killed by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      op_r        <= {NUM_OPS{1'b0}};
      illegal_r   <= 1'b0;
      rd_r        <= {REG_W{1'b0}};
      rs_r        <= {REG_W{1'b0}};
      imm_r       <= {(IW-3){1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      op_r        <= dec_op_s;
      illegal_r   <= dec_illegal_s;
      rd_r        <= dec_rd_s;
      rs_r        <= dec_rs_s;
      imm_r       <= dec_imm_s;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign op        = op_r;
  assign illegal   = illegal_r;
  assign rd        = rd_r;
  assign rs        = rs_r;
  assign imm       = imm_r;
  assign pausing   = pausing_r;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (IW=8, REG_W=2, PAUSE_CYCLES=4):
// directed scenarios followed by randomized traffic.
module tb_decode_stage;

  localparam int IW = 8;
  localparam int REG_W = 2;
  localparam int PC = 4;

  logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [IW-1:0] instr;
  logic [11:0] op;
  logic illegal, pausing;
  logic [REG_W-1:0] rd, rs;
  logic [IW-4:0] imm;

  decode_stage #(.IW(IW), .REG_W(REG_W), .PAUSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .out_valid(out_valid),
    .out_ready(out_ready), .op(op), .illegal(illegal), .rd(rd), .rs(rs),
    .imm(imm), .pausing(pausing)
  );

  typedef struct { int idx; int rd; int rs; int imm; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference decode from the opcode table (opcode = word / 4 for IW=8).
  function automatic exp_t ref_decode(input int w);
    int o;
    exp_t e;
    o = w / 4;
    e = '{-1, 0, 0, 0};
    if (o >= 32 && o < 40)      begin e.idx = 0; e.imm = w % 32; end
    else if (o >= 40 && o < 48) begin e.idx = 1; e.imm = w % 32; end
    else if (o < 8)             begin e.idx = 2; e.rd = (w / 8) % 4; e.imm = w % 8; end
    else if (o < 16)            begin e.idx = 3; e.rd = (w / 8) % 4; e.imm = w % 8; end
    else if (o < 20)            begin e.idx = 4; e.imm = w % 16; end
    else if (o < 24)            begin e.idx = 5; e.imm = w % 16; end
    else if (o == 24)           begin e.idx = 6; e.rd = w % 4; end
    else if (o >= 28 && o < 32) begin e.idx = 7; e.rd = (w / 4) % 4; e.rs = w % 4; end
    else if (o == 48)           begin e.idx = 8; e.rd = w % 4; end
    else if (o == 49)           begin e.idx = 9; e.rd = w % 4; end
    else if (o == 50)           begin e.idx = 10; e.rd = w % 4; end
    else if (o == 63)           begin e.idx = 11; end
    return e;
  endfunction

  // Model: handshake/stall rules per cycle; pushes expected results on accept.
  int  cyc = 0;
  int  ready_at = 0;
  bit  m_valid = 1'b0;
  bit  m_pause = 1'b0;
  always @(negedge clk) begin
    bit stall, exp_ready, acc, cons;
    exp_t e;
    #2;
    cyc++;
    if (reset) begin
      q.delete();
      m_valid = 1'b0;
      m_pause = 1'b0;
      ready_at = 0;
    end else begin
      stall = (cyc < ready_at);
      exp_ready = !flush && !stall && !(m_valid && m_pause) && (!m_valid || out_ready);
      chk("in_ready", int'(in_ready), int'(exp_ready));
      chk("pausing", int'(pausing), int'(stall));
      acc  = in_valid && exp_ready;
      cons = m_valid && out_ready;
      if (flush) begin
        m_valid = 1'b0;
        ready_at = 0;
      end else begin
        if (cons && m_pause) ready_at = cyc + 1 + PC;
        if (acc) begin
          e = ref_decode(int'(instr));
          q.push_back(e);
          m_valid = 1'b1;
          m_pause = (e.idx == 11);
        end else if (cons) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: whenever execute takes the output, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("op", int'(op), (e.idx < 0) ? 0 : (1 << e.idx));
        chk("illegal", int'(illegal), int'(e.idx < 0));
        chk("rd", int'(rd), e.rd);
        chk("rs", int'(rs), e.rs);
        chk("imm", int'(imm), e.imm);
      end else if (flush && q.size() > 0) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input bit r, input bit iv, input logic [7:0] w,
                      input bit ordy, input bit fl);
    @(negedge clk);
    reset = r; in_valid = iv; instr = w; out_ready = ordy; flush = fl;
  endtask

  task automatic check_cleared(input string tag);
    #3;
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_op"}, int'(op), 0);
    chk({tag, "_illegal"}, int'(illegal), 0);
    chk({tag, "_rd"}, int'(rd), 0);
    chk({tag, "_rs"}, int'(rs), 0);
    chk({tag, "_imm"}, int'(imm), 0);
    chk({tag, "_pausing"}, int'(pausing), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 8'h00;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_cleared("reset");

    // addi then br back to back
    step(1'b0, 1'b1, 8'h15, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h9D, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // mov held three cycles, consumed on the fourth
    step(1'b0, 1'b1, 8'h7D, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h15, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // pause then a waiting instruction
    step(1'b0, 1'b1, 8'hFC, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h15, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // illegal encodings and clr
    step(1'b0, 1'b1, 8'h64, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'hF8, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h61, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // flush while holding, with a competing offer
    step(1'b0, 1'b1, 8'h15, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h9D, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // flush during a pause stall
    step(1'b0, 1'b1, 8'hFC, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h15, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // reset while a pause is held
    step(1'b0, 1'b1, 8'hFC, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_cleared("mid_reset");

    // reset during the countdown
    step(1'b0, 1'b1, 8'hFC, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_cleared("stall_reset");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] w;
      w = ($urandom_range(0, 9) == 0) ? 8'hFC : 8'($urandom_range(0, 255));
      step(1'b0, 1'($urandom_range(0, 3) != 0), w,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end

    // drain
    for (int i = 0; i < PC + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
